mem_port_b_arbiter: RTL and testbench

- Shares port B of the dual-port Memory between three requesters: VGA fetch (R0, read-only), SNES button store (R1) and a debug/loader port (R2).
- R0 has fixed priority, with a starvation override for R1/R2; R1 and R2 arbitrate round-robin between themselves.
- Drives the Memory port-B address/data/write-enable.
- Returns read data with a per-requester valid strobe one cycle after grant, matching the synchronous BRAM read latency.

---
 rtl/mem_port_b_arbiter_if.sv | 42 ++++
 rtl/mem_port_b_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_b_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_b_arbiter_if.sv
// Port-B bus between the three memory requesters, the arbiter and the Memory.
// The arbiter uses the slave modport; requesters and Memory sit on the master side.
interface mem_port_b_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  req2;
  logic                  we2;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] wdata2;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt2;
  logic                  rvalid0;
  logic                  rvalid1;
  logic                  rvalid2;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] mem_out_b;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_wdata_b;
  logic                  mem_we_b;
  logic                  vga_stall;
  logic [15:0]           stall_count;

  modport slave (
    input  req0, addr0, req1, we1, addr1, wdata1, req2, we2, addr2, wdata2, mem_out_b,
    output gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           mem_addr_b, mem_wdata_b, mem_we_b, vga_stall, stall_count
  );

  modport master (
    output req0, addr0, req1, we1, addr1, wdata1, req2, we2, addr2, wdata2, mem_out_b,
    input  gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, rdata,
           mem_addr_b, mem_wdata_b, mem_we_b, vga_stall, stall_count
  );
endinterface

// File: rtl/mem_port_b_arbiter.sv
// Memory port-B arbiter: VGA fetch (R0) has fixed priority unless button store (R1)
// or debug (R2) has waited MAX_WAIT cycles; R1/R2 share round-robin between themselves.
module mem_port_b_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 8
) (
  input logic                 clk,
  input logic                 reset,
  mem_port_b_arbiter_if.slave bus
);
  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  logic [2:0]            req_vec;
  logic [2:0]            we_vec;
  logic [2:0]            gnt_vec;
  logic [2:1]            starved;
  logic                  tie_pick2;
  logic                  rr_last2_reg;
  logic                  rr_last2_next;
  logic [2:0]            rvalid_reg;
  logic                  vga_stall_reg;
  logic                  stall_now;
  logic [15:0]           stall_count_reg;
  logic [15:0]           stall_count_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next;

  assign req_vec = {bus.req2, bus.req1, bus.req0};
  assign we_vec  = {bus.we2, bus.we1, 1'b0};

  // Per-requester denial counters for R1 and R2.
  generate
    for (genvar gi = 1; gi <= 2; gi++) begin : g_wait
      logic [7:0] wait_reg;
      logic [7:0] wait_next;

      always_comb begin
        wait_next = wait_reg;
        if (gnt_vec[gi] || !req_vec[gi]) begin
          wait_next = 8'd0;
        end else if (wait_reg != 8'hFF) begin
          wait_next = wait_reg + 8'd1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wait_reg <= 8'd0;
        end else begin
          wait_reg <= wait_next;
        end
      end

      assign starved[gi] = req_vec[gi] && (wait_reg >= MAX_WAIT_W);
    end
  endgenerate

  // rr_last2_reg is 1 when R2 won the latest R1/R2 grant; ties go to the other one.
  assign tie_pick2 = ~rr_last2_reg;

  always_comb begin
    gnt_vec = 3'b000;
    if (reset) begin
      gnt_vec = 3'b000;
    end else if (&starved) begin
      gnt_vec = tie_pick2 ? 3'b100 : 3'b010;
    end else if (starved[1]) begin
      gnt_vec = 3'b010;
    end else if (starved[2]) begin
      gnt_vec = 3'b100;
    end else if (req_vec[0]) begin
      gnt_vec = 3'b001;
    end else if (req_vec[1] && req_vec[2]) begin
      gnt_vec = tie_pick2 ? 3'b100 : 3'b010;
    end else if (req_vec[1]) begin
      gnt_vec = 3'b010;
    end else if (req_vec[2]) begin
      gnt_vec = 3'b100;
    end
  end

  always_comb begin
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    if (gnt_vec[0]) begin
      mem_addr_next = bus.addr0;
    end else if (gnt_vec[1]) begin
      mem_addr_next  = bus.addr1;
      mem_wdata_next = bus.we1 ? bus.wdata1 : '0;
    end else if (gnt_vec[2]) begin
      mem_addr_next  = bus.addr2;
      mem_wdata_next = bus.we2 ? bus.wdata2 : '0;
    end
  end

  assign rr_last2_next    = gnt_vec[2] ? 1'b1 : (gnt_vec[1] ? 1'b0 : rr_last2_reg);
  assign stall_now        = req_vec[0] & ~gnt_vec[0];
  assign stall_count_next = (stall_now && stall_count_reg != 16'hFFFF)
                            ? stall_count_reg + 16'd1 : stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last2_reg    <= 1'b1;
      rvalid_reg      <= 3'b000;
      vga_stall_reg   <= 1'b0;
      stall_count_reg <= 16'd0;
    end else begin
      rr_last2_reg    <= rr_last2_next;
      rvalid_reg      <= gnt_vec & ~we_vec;
      vga_stall_reg   <= stall_now;
      stall_count_reg <= stall_count_next;
    end
  end

  assign bus.gnt0        = gnt_vec[0];
  assign bus.gnt1        = gnt_vec[1];
  assign bus.gnt2        = gnt_vec[2];
  assign bus.rvalid0     = rvalid_reg[0];
  assign bus.rvalid1     = rvalid_reg[1];
  assign bus.rvalid2     = rvalid_reg[2];
  assign bus.rdata       = bus.mem_out_b;
  assign bus.mem_addr_b  = mem_addr_next;
  assign bus.mem_wdata_b = mem_wdata_next;
  assign bus.mem_we_b    = |(gnt_vec & we_vec);
  assign bus.vga_stall   = vga_stall_reg;
  assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Bench for mem_port_b_arbiter: directed and random requests against a rule-level model,
// reads scored through a queue; a second instance with MAX_WAIT=1 drives stall_count to saturation.
module tb_mem_port_b_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 8;

  typedef struct {
    int          who;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  logic env_init;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_g   = -1;
  exp_t exp_q[$];

  int          m_w1, m_w2, m_rr, m_stall_cnt;
  bit          m_stall_prev;
  logic [15:0] ref_mem [0:65535];
  logic [15:0] env_mem [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_b_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_port_b_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  mem_port_b_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  mem_port_b_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(1)) dut_sat (
    .clk  (clk),
    .reset(reset2),
    .bus  (bus2.slave)
  );

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A3C);
  endfunction

  // Write-first synchronous BRAM standing in for the Memory on port B.
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 65536; i++) env_mem[i] <= dflt(16'(i));
      bus.mem_out_b <= '0;
    end else if (bus.mem_we_b) begin
      env_mem[bus.mem_addr_b] <= bus.mem_wdata_b;
      bus.mem_out_b           <= bus.mem_wdata_b;
    end else begin
      bus.mem_out_b <= env_mem[bus.mem_addr_b];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Priority rules: starved R1/R2 first (tie to the one that did not win last),
  // then R0, then R1/R2 round-robin. Returns -1 when nobody requests.
  function automatic int arbitrate(input int w1, input int w2, input int rr,
                                   input bit r0, input bit r1, input bit r2, input int maxw);
    bit s1, s2;
    int tie;
    s1  = r1 && (w1 >= maxw);
    s2  = r2 && (w2 >= maxw);
    tie = (rr == 1) ? 2 : 1;
    if (s1 && s2) return tie;
    if (s1) return 1;
    if (s2) return 2;
    if (r0) return 0;
    if (r1 && r2) return tie;
    if (r1) return 1;
    if (r2) return 2;
    return -1;
  endfunction

  function automatic int next_wait(input int w, input bit granted, input bit r);
    if (granted || !r) return 0;
    return (w < 255) ? w + 1 : 255;
  endfunction

  function automatic logic [15:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 16'h0100 : 16'($urandom_range(0, 15));
  endfunction

  // Called at posedge+1 with inputs already applied; checks at +3, returns at next posedge+1.
  task automatic step();
    int          g, eg;
    bit          r0, r1, r2, we;
    logic [15:0] addr, wdata;
    exp_t        e;
    #2;
    if (reset) begin
      chk("gnt_in_reset", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'd0);
      chk("we_in_reset", 32'(bus.mem_we_b), 32'd0);
      chk("rvalid_in_reset", 32'({bus.rvalid2, bus.rvalid1, bus.rvalid0}), 32'd0);
      chk("stall_cnt_in_reset", 32'(bus.stall_count), 32'd0);
      m_w1 = 0; m_w2 = 0; m_rr = 2; m_stall_cnt = 0; m_stall_prev = 0;
      exp_q.delete();
      last_g = -1;
    end else begin
      r0 = bus.req0; r1 = bus.req1; r2 = bus.req2;
      g  = arbitrate(m_w1, m_w2, m_rr, r0, r1, r2, MW);
      eg = (g < 0) ? 0 : (1 << g);
      addr  = (g == 0) ? bus.addr0 : (g == 1) ? bus.addr1 : (g == 2) ? bus.addr2 : 16'h0000;
      we    = (g == 1 && bus.we1) || (g == 2 && bus.we2);
      wdata = !we ? 16'h0000 : (g == 1) ? bus.wdata1 : bus.wdata2;
      chk("gnt", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'(eg));
      chk("mem_addr_b", 32'(bus.mem_addr_b), 32'(addr));
      chk("mem_we_b", 32'(bus.mem_we_b), 32'(we));
      chk("mem_wdata_b", 32'(bus.mem_wdata_b), 32'(wdata));
      chk("vga_stall", 32'(bus.vga_stall), 32'(m_stall_prev));
      chk("stall_count", 32'(bus.stall_count), 32'(m_stall_cnt));
      if (we) begin
        ref_mem[addr] = wdata;
      end else if (g >= 0) begin
        e.who = g; e.data = ref_mem[addr]; e.due = cyc + 1;
        exp_q.push_back(e);
      end
      m_stall_prev = r0 && (g != 0);
      if (m_stall_prev && m_stall_cnt < 65535) m_stall_cnt++;
      m_w1 = next_wait(m_w1, g == 1, r1);
      m_w2 = next_wait(m_w2, g == 2, r2);
      if (g == 1 || g == 2) m_rr = g;
      last_g = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
    bus.we1 = 0; bus.we2 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wdata1 = '0; bus.wdata2 = '0;
  endtask

  task automatic drive_random();
    if (!bus.req0 || last_g == 0) begin
      bus.req0 = ($urandom_range(0, 99) < 50);
      bus.addr0 = rand_addr();
    end
    if (!bus.req1 || last_g == 1) begin
      bus.req1 = ($urandom_range(0, 99) < 40);
      bus.we1 = 1'($urandom_range(0, 1));
      bus.addr1 = rand_addr();
      bus.wdata1 = 16'($urandom);
    end
    if (!bus.req2 || last_g == 2) begin
      bus.req2 = ($urandom_range(0, 99) < 40);
      bus.we2 = 1'($urandom_range(0, 1));
      bus.addr2 = rand_addr();
      bus.wdata2 = 16'($urandom);
    end
    reset = ($urandom_range(0, 199) == 0);
  endtask

  // Read scoreboard: every predicted read must show up exactly one cycle after its grant.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] rv;
    rv = {bus.rvalid2, bus.rvalid1, bus.rvalid0};
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rvalid", 32'(rv), 32'(1 << e.who));
      chk("rdata", 32'(bus.rdata), 32'(e.data));
    end else if (rv != 3'b000) begin
      chk("rvalid_unexpected", 32'(rv), 32'd0);
    end
  end

  task automatic run_main();
    reset = 1; env_init = 1;
    clear_reqs();
    for (int i = 0; i < 65536; i++) ref_mem[i] = dflt(16'(i));
    m_w1 = 0; m_w2 = 0; m_rr = 2; m_stall_cnt = 0; m_stall_prev = 0;
    @(posedge clk);
    #1;
    env_init = 0;
    step();
    bus.req0 = 1; bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0007; bus.wdata1 = 16'h1234;
    step();
    reset = 0;
    clear_reqs();
    step(); step();

    bus.req0 = 1; bus.addr0 = 16'h0100;
    step();
    clear_reqs();
    step(); step();

    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h2000; bus.wdata1 = 16'h0ABC;
    bus.req2 = 1; bus.we2 = 0; bus.addr2 = 16'h2000;
    repeat (4) step();
    clear_reqs();
    step(); step();

    bus.req0 = 1; bus.addr0 = 16'h0010;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0011;
    repeat (12) step();
    clear_reqs();
    step(); step();

    bus.req0 = 1; bus.addr0 = 16'h0020;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0021;
    bus.req2 = 1; bus.we2 = 0; bus.addr2 = 16'h0022;
    repeat (14) step();
    clear_reqs();
    step(); step();

    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0005;
    step();
    reset = 1;
    clear_reqs();
    step();
    reset = 0;
    step(); step();

    for (int k = 0; k < 3000; k++) begin
      drive_random();
      step();
    end
    reset = 0;
    clear_reqs();
    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // With MAX_WAIT=1 and all three requesting, R1/R2 alternate forever and R0 stalls every cycle.
  task automatic run_sat();
    int w1 = 0, w2 = 0, rr = 2, cnt = 0, g;
    bit prev = 0;
    reset2 = 1;
    bus2.req0 = 0; bus2.req1 = 0; bus2.req2 = 0;
    bus2.we1 = 0; bus2.we2 = 0;
    bus2.addr0 = '0; bus2.addr1 = '0; bus2.addr2 = '0;
    bus2.wdata1 = '0; bus2.wdata2 = '0;
    bus2.mem_out_b = '0;
    @(posedge clk);
    #1;
    reset2 = 0;
    bus2.req0 = 1; bus2.req1 = 1; bus2.req2 = 1;
    for (int k = 0; k < 70100; k++) begin
      #2;
      g = arbitrate(w1, w2, rr, 1'b1, 1'b1, 1'b1, 1);
      if (k < 20 || k % 5000 == 0) begin
        chk("sat_gnt", 32'({bus2.gnt2, bus2.gnt1, bus2.gnt0}), 32'(1 << g));
        chk("sat_vga_stall", 32'(bus2.vga_stall), 32'(prev));
        chk("sat_stall_count", 32'(bus2.stall_count), 32'(cnt));
      end
      prev = (g != 0);
      if (prev && cnt < 65535) cnt++;
      w1 = next_wait(w1, g == 1, 1'b1);
      w2 = next_wait(w2, g == 2, 1'b1);
      if (g == 1 || g == 2) rr = g;
      @(posedge clk);
      #1;
    end
    #2;
    chk("sat_final_count", 32'(bus2.stall_count), 32'(cnt));
  endtask

  initial begin
    fork
      run_main();
      run_sat();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
